oled_text_ctrl: RTL

//  Text-console sequencer between uart_rx and oled_display. Buffers received bytes in a

---
 rtl/oled_text_ctrl.sv | 198 +++++++++++++++++++
 1 files changed

// File: rtl/oled_text_ctrl.sv
// rtl/oled_text_ctrl.sv - text-console sequencer between uart_rx and the OLED driver
//
// Received bytes pass through an input register and a small FIFO. A command
// FSM pops one byte at a time, interprets printable codes and BS/CR/LF/FF,
// tracks the text cursor, and issues a single draw or clear request to the
// OLED driver. Each request is held until the driver acknowledges it.
module oled_text_ctrl #(
  parameter int COLS       = 16,
  parameter int ROWS       = 4,
  parameter int FIFO_DEPTH = 16,
  localparam int COL_W     = $clog2(COLS),
  localparam int ROW_W     = $clog2(ROWS)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [7:0]       rx_data,
  input  logic             rx_valid,
  output logic [7:0]       chr_code,
  output logic [COL_W-1:0] chr_col,
  output logic [ROW_W-1:0] chr_row,
  output logic             chr_req,
  input  logic             chr_ack,
  output logic             clr_req,
  input  logic             clr_ack,
  output logic             overflow,
  output logic             busy
);

  localparam int AW = $clog2(FIFO_DEPTH);
  localparam logic [COL_W-1:0] COL_MAX = COL_W'(COLS - 1);
  localparam logic [ROW_W-1:0] ROW_MAX = ROW_W'(ROWS - 1);
  localparam logic [AW:0]      FULL_CNT = (AW + 1)'(FIFO_DEPTH);

  typedef enum logic [1:0] {
    IDLE,
    DECODE,
    DRAW,
    CLEAR
  } state_t;

  state_t           state;
  logic [7:0]       in_data;
  logic             in_valid;
  logic [7:0]       mem [FIFO_DEPTH];
  logic [AW-1:0]    wr_ptr;
  logic [AW-1:0]    rd_ptr;
  logic [AW:0]      count;
  logic             fifo_full;
  logic             push;
  logic             pop;
  logic             clr_done;
  logic [7:0]       cur_byte;
  logic             draw_bs;
  logic [COL_W-1:0] col;
  logic [ROW_W-1:0] row;

  assign fifo_full = (count == FULL_CNT);
  assign push      = in_valid && !fifo_full;
  assign pop       = (state == IDLE) && (count != '0);
  assign clr_done  = (state == CLEAR) && clr_ack;
  assign busy      = (state != IDLE) || (count != '0);

  // Register the UART strobe and byte before they enter the FIFO.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      in_data  <= '0;
      in_valid <= 1'b0;
    end else begin
      in_data  <= rx_data;
      in_valid <= rx_valid;
    end
  end

  // FIFO storage; contents need no reset because the pointers gate every read.
  always_ff @(posedge clk) begin
    if (push) begin
      mem[wr_ptr] <= in_data;
    end
  end

  // FIFO pointers, occupancy and the sticky overflow flag.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      count    <= '0;
      overflow <= 1'b0;
    end else begin
      if (push) begin
        wr_ptr <= wr_ptr + 1'b1;
      end
      if (pop) begin
        rd_ptr <= rd_ptr + 1'b1;
      end
      if (push && !pop) begin
        count <= count + 1'b1;
      end else if (pop && !push) begin
        count <= count - 1'b1;
      end
      // A dropped byte outranks a clear finishing in the same cycle.
      if (in_valid && fifo_full) begin
        overflow <= 1'b1;
      end else if (clr_done) begin
        overflow <= 1'b0;
      end
    end
  end

  // Command FSM: decode one byte, update the cursor, run the driver handshake.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state    <= IDLE;
      cur_byte <= '0;
      draw_bs  <= 1'b0;
      col      <= '0;
      row      <= '0;
      chr_code <= '0;
      chr_col  <= '0;
      chr_row  <= '0;
      chr_req  <= 1'b0;
      clr_req  <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (pop) begin
            cur_byte <= mem[rd_ptr];
            state    <= DECODE;
          end
        end

        DECODE: begin
          if (cur_byte >= 8'h20 && cur_byte <= 8'h7E) begin
            chr_code <= cur_byte;
            chr_col  <= col;
            chr_row  <= row;
            chr_req  <= 1'b1;
            draw_bs  <= 1'b0;
            state    <= DRAW;
          end else if (cur_byte == 8'h08) begin
            // Backspace erases the cell to the left; at column 0 it does nothing.
            if (col != '0) begin
              col      <= col - 1'b1;
              chr_code <= 8'h20;
              chr_col  <= col - 1'b1;
              chr_row  <= row;
              chr_req  <= 1'b1;
              draw_bs  <= 1'b1;
              state    <= DRAW;
            end else begin
              state <= IDLE;
            end
          end else if (cur_byte == 8'h0D) begin
            col   <= '0;
            state <= IDLE;
          end else if (cur_byte == 8'h0A) begin
            row   <= (row == ROW_MAX) ? '0 : row + 1'b1;
            state <= IDLE;
          end else if (cur_byte == 8'h0C) begin
            clr_req <= 1'b1;
            state   <= CLEAR;
          end else begin
            state <= IDLE;
          end
        end

        DRAW: begin
          if (chr_ack) begin
            chr_req <= 1'b0;
            // Printable glyphs advance the cursor; the backspace blank does not.
            if (!draw_bs) begin
              if (col == COL_MAX) begin
                col <= '0;
                row <= (row == ROW_MAX) ? '0 : row + 1'b1;
              end else begin
                col <= col + 1'b1;
              end
            end
            state <= IDLE;
          end
        end

        CLEAR: begin
          if (clr_ack) begin
            clr_req <= 1'b0;
            col     <= '0;
            row     <= '0;
            state   <= IDLE;
          end
        end

        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

endmodule
